// File: rtl/cpu_types_pkg.sv
// Shared CPU types plus the ALU BIST constants, state encoding and MISR step.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_NOR  = 4'd5,
      ALU_SLL  = 4'd6,
      ALU_SRL  = 4'd7,
      ALU_SLT  = 4'd8,
      ALU_SLTU = 4'd9
   } aluop_t;

   localparam word_t BIST_LFSR_POLY = 32'h80200003;
   localparam word_t BIST_MISR_POLY = 32'h04C11DB7;

   typedef enum logic [2:0] {
      BIST_IDLE,
      BIST_SEED,
      BIST_DRIVE,
      BIST_CAPTURE,
      BIST_DONE
   } bist_state_t;

   // One MISR compaction step: CRC-32 style shift, then fold in result and flags.
   function automatic word_t misr_step(input word_t sig, input word_t data,
                                       input logic [2:0] flags);
      return {sig[30:0], 1'b0} ^ (sig[31] ? BIST_MISR_POLY : '0) ^ data ^ {29'b0, flags};
   endfunction

endpackage

// File: rtl/alu_if.sv
// Connection bundle between an ALU and whatever drives it (here the BIST).
interface alu_if;
   import cpu_types_pkg::*;

   aluop_t aluop;
   word_t  porta;
   word_t  portb;
   word_t  portout;
   logic   negative;
   logic   overflow;
   logic   zero;

   modport tb  (output aluop, porta, portb, input portout, negative, overflow, zero);
   modport alu (input aluop, porta, portb, output portout, negative, overflow, zero);
endinterface

// File: rtl/bist_lfsr32.sv
// 32-bit right-shifting Galois LFSR with synchronous seed load and step enable.
module bist_lfsr32 #(
   parameter logic [31:0] POLY = 32'h80200003,
   parameter logic [31:0] SEED = 32'hACE12345
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_load,
   input  logic        i_step,
   output logic [31:0] o_state
);

   logic [31:0] r_state;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= '0;
      end else if (i_load) begin
         r_state <= SEED;
      end else if (i_step) begin
         r_state <= (r_state >> 1) ^ (r_state[0] ? POLY : 32'h0);
      end
   end

   assign o_state = r_state;

endmodule

// File: rtl/alu_bist.sv
// ALU built-in self test: LFSR operands per op/vector, MISR compaction of the ALU
// result and flags, final comparison against a golden signature.
module alu_bist
   import cpu_types_pkg::*;
#(
   parameter int    NVEC = 16,
   parameter int    NOPS = 10,
   parameter word_t SEED = 32'hACE12345
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        start,
   input  word_t       golden_sig,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output word_t       signature,
   output bist_state_t dbg_state,
   alu_if.tb           aluif
);

   // start is a level, looked at only in IDLE/DONE; while busy it is ignored entirely.
   bist_state_t r_state, w_state_nxt;
   logic [4:0]  r_op;
   logic [8:0]  r_vec;
   word_t       r_sig, w_sig_nxt;
   logic        r_pass;
   aluop_t      r_aluop;
   word_t       r_porta, r_portb;
   word_t       w_lfsr;
   logic        w_lfsr_load, w_lfsr_step;
   logic        w_last_vec, w_last_op;

   bist_lfsr32 #(
      .POLY (BIST_LFSR_POLY),
      .SEED (SEED)
   ) u_lfsr (
      .i_clk   (CLK),
      .i_rst   (RST),
      .i_load  (w_lfsr_load),
      .i_step  (w_lfsr_step),
      .o_state (w_lfsr)
   );

   assign w_last_vec = (r_vec == 9'(NVEC - 1));
   assign w_last_op  = (r_op == 5'(NOPS - 1));
   assign w_sig_nxt  = misr_step(r_sig, aluif.portout,
                                 {aluif.negative, aluif.overflow, aluif.zero});

   always_comb begin
      w_state_nxt = r_state;
      w_lfsr_load = 1'b0;
      w_lfsr_step = 1'b0;
      case (r_state)
         BIST_IDLE, BIST_DONE: if (start) w_state_nxt = BIST_SEED;
         BIST_SEED: begin
            w_lfsr_load = 1'b1;
            w_state_nxt = BIST_DRIVE;
         end
         BIST_DRIVE: begin
            w_lfsr_step = 1'b1;
            w_state_nxt = BIST_CAPTURE;
         end
         BIST_CAPTURE: w_state_nxt = (w_last_vec && w_last_op) ? BIST_DONE : BIST_DRIVE;
         default: w_state_nxt = BIST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) r_state <= BIST_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_op    <= '0;
         r_vec   <= '0;
         r_sig   <= '0;
         r_pass  <= 1'b0;
         r_aluop <= ALU_ADD;
         r_porta <= '0;
         r_portb <= '0;
      end else begin
         case (r_state)
            // pass drops as soon as a new run is accepted, not one cycle later
            BIST_IDLE, BIST_DONE: if (start) r_pass <= 1'b0;
            BIST_SEED: begin
               r_sig  <= '0;
               r_op   <= '0;
               r_vec  <= '0;
               r_pass <= 1'b0;
            end
            BIST_DRIVE: begin
               r_aluop <= aluop_t'(r_op[3:0]);
               r_porta <= w_lfsr;
               r_portb <= {w_lfsr[15:0], w_lfsr[31:16]};
            end
            BIST_CAPTURE: begin
               r_sig <= w_sig_nxt;
               if (w_last_vec) begin
                  r_vec <= '0;
                  r_op  <= r_op + 5'd1;
               end else begin
                  r_vec <= r_vec + 9'd1;
               end
               if (w_last_vec && w_last_op) r_pass <= (w_sig_nxt == golden_sig);
            end
            default: ;
         endcase
      end
   end

   assign aluif.aluop = r_aluop;
   assign aluif.porta = r_porta;
   assign aluif.portb = r_portb;

   assign busy      = (r_state == BIST_SEED) || (r_state == BIST_DRIVE) ||
                      (r_state == BIST_CAPTURE);
   assign done      = (r_state == BIST_DONE);
   assign pass      = r_pass;
   assign signature = r_sig;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_alu_bist.sv
// Bench for alu_bist: a behavioural ALU on the interface, a per-vector reference
// model of operands and signatures, a cycle-by-cycle compare process, directed runs.
module tb_alu_bist;
   import cpu_types_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, start, start_s, inj;
   word_t       golden, golden_s, inj_a;
   logic        busy, done, pass, busy_s, done_s, pass_s;
   word_t       sig, sig_s;
   bist_state_t dbg, dbg_s;

   alu_if u_if ();
   alu_if u_if_s ();

   alu_bist u_dut (
      .CLK(clk), .RST(rst), .start(start), .golden_sig(golden),
      .busy(busy), .done(done), .pass(pass), .signature(sig),
      .dbg_state(dbg), .aluif(u_if)
   );

   alu_bist #(.NVEC(1), .NOPS(1)) u_small (
      .CLK(clk), .RST(rst), .start(start_s), .golden_sig(golden_s),
      .busy(busy_s), .done(done_s), .pass(pass_s), .signature(sig_s),
      .dbg_state(dbg_s), .aluif(u_if_s)
   );

   // ---------------- behavioural ALU: {result, negative, overflow, zero} ----------------
   function automatic logic [34:0] alu_eval(input aluop_t op, input word_t a, input word_t b);
      word_t y;
      logic  v;
      v = 1'b0;
      case (op)
         ALU_ADD:  begin y = a + b; v = (a[31] == b[31]) && (y[31] != a[31]); end
         ALU_SUB:  begin y = a - b; v = (a[31] != b[31]) && (y[31] != a[31]); end
         ALU_AND:  y = a & b;
         ALU_OR:   y = a | b;
         ALU_XOR:  y = a ^ b;
         ALU_NOR:  y = ~(a | b);
         ALU_SLL:  y = a << b[4:0];
         ALU_SRL:  y = a >> b[4:0];
         ALU_SLT:  y = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         ALU_SLTU: y = (a < b) ? 32'd1 : 32'd0;
         default:  y = 32'd0;
      endcase
      return {y, y[31], v, (y == 32'd0)};
   endfunction

   logic [34:0] w_res, w_res_s;
   assign w_res   = alu_eval(u_if.aluop, u_if.porta, u_if.portb);
   assign w_res_s = alu_eval(u_if_s.aluop, u_if_s.porta, u_if_s.portb);
   assign u_if.portout  = w_res[34:3] ^ {31'b0, inj && (u_if.aluop == ALU_OR) && (u_if.porta == inj_a)};
   assign u_if.negative = w_res[2];
   assign u_if.overflow = w_res[1];
   assign u_if.zero     = w_res[0];
   assign u_if_s.portout  = w_res_s[34:3];
   assign u_if_s.negative = w_res_s[2];
   assign u_if_s.overflow = w_res_s[1];
   assign u_if_s.zero     = w_res_s[0];

   // ---------------- reference model ----------------
   word_t exp_a [0:255];
   word_t exp_b [0:255];
   int    exp_op[0:255];
   word_t exp_sig[0:256];
   int    m_n;
   bit    exp_pass;
   word_t golden_clean;

   task automatic build_model(input int nv, input int no, input bit fault);
      word_t       l, s, y;
      logic [34:0] r;
      int          idx;
      idx = 0;
      l = 32'hACE12345;
      exp_sig[0] = 32'h0;
      for (int op = 0; op < no; op++) begin
         for (int v = 0; v < nv; v++) begin
            exp_op[idx] = op;
            exp_a[idx]  = l;
            exp_b[idx]  = {l[15:0], l[31:16]};
            l = l[0] ? ((l >> 1) ^ 32'h80200003) : (l >> 1);
            r = alu_eval(aluop_t'(4'(op)), exp_a[idx], exp_b[idx]);
            y = r[34:3];
            if (fault && op == 3 && v == 5) y[0] = ~y[0];
            s = exp_sig[idx];
            exp_sig[idx+1] = {s[30:0], 1'b0} ^ (s[31] ? 32'h04C11DB7 : 32'h0) ^ y ^ {29'b0, r[2:0]};
            idx++;
         end
      end
      m_n = idx;
   endtask

   // ---------------- scoreboard counters ----------------
   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // ---------------- compare process (default-parameter instance) ----------------
   int mon_e  = 0;
   bit mon_on = 1'b0;
   bit run_done = 1'b0;
   int mk;

   always @(posedge clk) begin
      #1;
      if (mon_on) begin
         mon_e = mon_e + 1;
         if (mon_e == 1) begin
            chk("seed_busy", 32'(busy), 32'd1);
            chk("seed_done", 32'(done), 32'd0);
            chk("seed_pass", 32'(pass), 32'd0);
         end else begin
            if (mon_e % 2 == 0) begin
               mk = (mon_e - 2) / 2;
               chk("sig_after_vec", sig, exp_sig[mk]);
            end else begin
               mk = (mon_e - 1) / 2 - 1;
               chk("sig_in_capture", sig, exp_sig[mk]);
               chk("aluop", 32'(u_if.aluop), 32'(exp_op[mk]));
               chk("porta", u_if.porta, exp_a[mk]);
               chk("portb", u_if.portb, exp_b[mk]);
            end
            chk("busy", 32'(busy), 32'(mon_e < 2 * m_n + 2));
            chk("done", 32'(done), 32'(mon_e == 2 * m_n + 2));
            if (mon_e == 2 * m_n + 2) begin
               chk("pass", 32'(pass), 32'(exp_pass));
               mon_on   = 1'b0;
               run_done = 1'b1;
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic do_run(input bit hold, input bit fault);
      build_model(16, 10, fault);
      exp_pass = (exp_sig[m_n] == golden_clean);
      golden   = golden_clean;
      inj      = fault;
      inj_a    = exp_a[3*16+5];
      @(negedge clk);
      start    = 1'b1;
      mon_e    = 0;
      run_done = 1'b0;
      mon_on   = 1'b1;
      if (!hold) begin
         @(negedge clk);
         start = 1'b0;
      end
      for (int i = 0; i < 1000 && !run_done; i++) @(negedge clk);
      start = 1'b0;
      if (!run_done) begin
         checks++;
         errors++;
         $display("FAIL run_timeout actual=no_done required=done_on_edge_%0d", 2 * m_n + 2);
         mon_on = 1'b0;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "bench timeout");
   end

   // ---------------- stimulus ----------------
   initial begin
      rst = 1'b1; start = 1'b0; start_s = 1'b0; inj = 1'b0;
      golden = '0; golden_s = 32'hD026D022; inj_a = '0;
      #3;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_pass", 32'(pass), 32'd0);
      chk("rst_sig", sig, 32'd0);
      chk("rst_porta", u_if.porta, 32'd0);
      chk("rst_aluop", 32'(u_if.aluop), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // model pins: first two LFSR words, word swap, ADD of first pair
      build_model(1, 1, 1'b0);
      chk("model_sig_1x1", exp_sig[1], 32'hD026D022);
      build_model(16, 10, 1'b0);
      chk("model_a0", exp_a[0], 32'hACE12345);
      chk("model_b0", exp_b[0], 32'h2345ACE1);
      chk("model_a1", exp_a[1], 32'hD65091A1);
      chk("model_op16", 32'(exp_op[16]), 32'd1);
      golden_clean = exp_sig[m_n];

      // NVEC=1, NOPS=1: DONE on edge 4
      @(negedge clk);
      start_s = 1'b1;
      @(posedge clk); #1;
      chk("s_e1_busy", 32'(busy_s), 32'd1);
      @(negedge clk);
      start_s = 1'b0;
      @(posedge clk); #1;
      chk("s_e2_done", 32'(done_s), 32'd0);
      @(posedge clk); #1;
      chk("s_cap_aluop", 32'(u_if_s.aluop), 32'd0);
      chk("s_cap_porta", u_if_s.porta, 32'hACE12345);
      chk("s_cap_portb", u_if_s.portb, 32'h2345ACE1);
      chk("s_e3_done", 32'(done_s), 32'd0);
      @(posedge clk); #1;
      chk("s_e4_done", 32'(done_s), 32'd1);
      chk("s_e4_busy", 32'(busy_s), 32'd0);
      chk("s_sig", sig_s, 32'hD026D022);
      chk("s_pass", 32'(pass_s), 32'd1);

      do_run(1'b0, 1'b0);                          // clean run from IDLE
      chk("a_sig", sig, golden_clean);
      do_run(1'b0, 1'b0);                          // restart from DONE
      chk("b_sig", sig, golden_clean);
      do_run(1'b1, 1'b0);                          // start held through the run
      chk("c_sig", sig, golden_clean);
      do_run(1'b0, 1'b1);                          // portout[0] flipped at op 3, vec 5
      chk("d_sig_differs", 32'(sig != golden_clean), 32'd1);
      chk("d_sig_model", sig, exp_sig[m_n]);
      inj = 1'b0;

      // reset in the middle of a run
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (100) @(negedge clk);
      chk("mid_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      #1;
      chk("mrst_busy", 32'(busy), 32'd0);
      chk("mrst_done", 32'(done), 32'd0);
      chk("mrst_pass", 32'(pass), 32'd0);
      chk("mrst_sig", sig, 32'd0);
      chk("mrst_porta", u_if.porta, 32'd0);
      chk("mrst_portb", u_if.portb, 32'd0);
      chk("mrst_aluop", 32'(u_if.aluop), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      chk("post_busy", 32'(busy), 32'd0);
      chk("post_done", 32'(done), 32'd0);
      chk("post_state", 32'(dbg), 32'(BIST_IDLE));

      // ---------------- report ----------------
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_bist.md
ALU_BIST -- requirements
Module: alu_bist

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-002 Parameter NVEC, default 16: test vectors applied per ALU operation, range 1..256.
REQ-003 Parameter NOPS, default 10: number of aluop_t encodings exercised, 0..NOPS-1, range 1..16.
REQ-004 Parameter SEED, default 32'hACE12345: operand LFSR seed, SHALL be nonzero.
REQ-005 CLK  input  1  system clock, all state on rising edge.
REQ-006 RST  input  1  asynchronous active-high reset.
REQ-007 start  input  1  begin a test run; sampled only in IDLE or DONE.
REQ-008 golden_sig  input  32  expected final signature; sampled on entry to DONE.
REQ-009 busy  output  1  high in SEED, DRIVE and CAPTURE.
REQ-010 done  output  1  high while in DONE.
REQ-011 pass  output  1  high in DONE when signature == golden_sig; 0 otherwise.
REQ-012 signature  output  32  current MISR value.
REQ-013 aluif  alu_if.tb modport: drives aluop, porta, portb; receives portout, negative, overflow, zero.

Function
REQ-014 FSM states: IDLE, SEED, DRIVE, CAPTURE, DONE.
REQ-015 IDLE or DONE with start=1 -> SEED; otherwise remain in the current state.
REQ-016 SEED, one cycle: lfsr<=SEED, signature<=0, op counter<=0, vec counter<=0, pass<=0 -> DRIVE.
REQ-017 DRIVE, one cycle: register aluop<=op, porta<=lfsr, portb<={lfsr[15:0],lfsr[31:16]}, advance lfsr one step -> CAPTURE.
REQ-018 LFSR: 32-bit Galois, shift right, XOR 32'h80200003 into the state when the shifted-out bit is 1; not reseeded between ops.
REQ-019 CAPTURE, one cycle: signature <= {signature[30:0],1'b0} ^ (signature[31] ? 32'h04C11DB7 : 0) ^ portout ^ {29'b0,negative,overflow,zero}.
REQ-020 CAPTURE counters: vec increments; on vec==NVEC-1, vec<=0 and op increments; on op==NOPS-1 and vec==NVEC-1 -> DONE, otherwise -> DRIVE.
REQ-021 Loop order: op is the outer loop and vec the inner loop, so all NVEC vectors of op 0 precede op 1.
REQ-022 DONE entry: pass<=(signature_next==golden_sig); the block holds signature, pass and the ALU port values until the next start or reset.
REQ-023 Latency: counting the start-sampling edge as edge 1, DONE is entered on edge 2+2*NVEC*NOPS.
REQ-024 start while busy SHALL be ignored, with no restart or counter change.
REQ-025 ALU inputs aluop, porta and portb SHALL be registered outputs, stable for the whole CAPTURE cycle.
REQ-026 Counters SHALL be sized for the parameter maxima; wrap-around never occurs within a run.

Reset
REQ-027 RST=1 forces IDLE and clears lfsr, signature, counters, pass, done, busy, aluop, porta and portb to 0, all asynchronously.
REQ-028 Reset mid-run aborts the run with no partial done/pass; a new start is required after release.

Structure
REQ-029 aluop_t and word_t come from cpu_types_pkg; the BIST polynomial constants and the state enum are added to cpu_types_pkg.
REQ-030 The block contains one sub-module, bist_lfsr32, a parameterised Galois LFSR used for the operand generator; the MISR is implemented inline.

Verification
REQ-031 Reset: assert RST mid-run -> busy=0, done=0, pass=0, signature=0, porta=portb=0, aluop=0 within the same cycle.
REQ-032 NVEC=1, NOPS=1, start pulse -> in CAPTURE, aluop=0, porta=32'hACE12345, portb=32'h2345ACE1; done rises on edge 4.
REQ-033 Default parameters with the real alu connected and golden_sig from the bench model -> done after 322 edges, pass=1, signature equals the model value.
REQ-034 As REQ-033, but force portout[0] inverted for op 3, vec 5 -> pass=0 and signature differs from the model.
REQ-035 Assert start at every cycle of a busy run -> run length and signature identical to the REQ-033 result.
REQ-036 Second start from DONE -> SEED clears the signature and the run repeats bit-exactly, with pass=1 again.
